// File: rtl/stage_exerciser_if.sv
// Handshake and data bundle between the stage exerciser and the stage under test / run controller.
interface stage_exerciser_if;
    logic       start;
    logic       mode;
    logic [3:0] stage_from;
    logic [3:0] stage_to;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] first_err_idx;
    logic [3:0] first_err_data;

    modport master (
        input  start, mode, stage_to,
        output stage_from, busy, done, pass, err_count, first_err_idx, first_err_data
    );

    modport slave (
        output start, mode, stage_to,
        input  stage_from, busy, done, pass, err_count, first_err_idx, first_err_data
    );
endinterface

// File: rtl/stage_exerciser.sv
// Drives a deterministic vector sequence into a single-register 4-bit transform stage and
// checks the stage output two edges later, counting mismatches and capturing the first one.
module stage_exerciser #(
    parameter int unsigned NUM_VECTORS = 16,
    parameter logic [3:0]  SEED        = 4'h1
) (
    input  logic              clk,
    input  logic              rst,
    stage_exerciser_if.master bus
);
    // state   | meaning
    // S_IDLE  | waiting for start after reset
    // S_RUN   | issuing one vector per cycle
    // S_DRAIN | last vector sits in the stage, final compare
    // S_DONE  | results held until next start
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t     r_state;
    logic [8:0] r_idx;
    logic       r_mode;
    logic [3:0] r_from;
    logic       r_chk_valid;
    logic [7:0] r_chk_idx;
    logic [3:0] r_chk_exp;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [7:0] r_err;
    logic [7:0] r_fidx;
    logic [3:0] r_fdata;

    logic [7:0] w_idx_prev;
    logic [3:0] w_exp;
    logic       w_mismatch;
    logic       w_last;

    // r_idx points one past the vector currently on stage_from
    assign w_idx_prev = r_idx[7:0] - 8'd1;
    assign w_exp      = r_mode ? (r_from + 4'd1) : (r_from ^ 4'hC);
    assign w_mismatch = r_chk_valid && (bus.stage_to != r_chk_exp);
    assign w_last     = (r_idx == 9'(NUM_VECTORS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 9'd0;
            r_mode      <= 1'b0;
            r_from      <= 4'h0;
            r_chk_valid <= 1'b0;
            r_chk_idx   <= 8'd0;
            r_chk_exp   <= 4'h0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= 8'd0;
            r_fidx      <= 8'd0;
            r_fdata     <= 4'h0;
        end else begin
            // the stage latches stage_from on this edge; its output is compared on the next one
            r_chk_valid <= (r_state == S_RUN);
            r_chk_idx   <= w_idx_prev;
            r_chk_exp   <= w_exp;

            if (w_mismatch) begin
                if (r_err != 8'hFF) r_err <= r_err + 8'd1;
                if (r_err == 8'd0) begin
                    r_fidx  <= r_chk_idx;
                    r_fdata <= bus.stage_to;
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_idx   <= 9'd1;
                        r_mode  <= bus.mode;
                        r_from  <= SEED;
                        r_err   <= 8'd0;
                        r_fidx  <= 8'd0;
                        r_fdata <= 4'h0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_from <= r_idx[3:0] ^ SEED;
                        r_idx  <= r_idx + 9'd1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (r_err == 8'd0) && !w_mismatch;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stage_from     = r_from;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.err_count      = r_err;
    assign bus.first_err_idx  = r_fidx;
    assign bus.first_err_data = r_fdata;
endmodule

// File: tb/tb_stage_exerciser.sv
// Bench for stage_exerciser: behavioural stage models feed two DUTs (16 and 256 vectors),
// results are compared against a table of known outcomes and a run-level reference model.
module tb_stage_exerciser;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stage_exerciser_if if16 ();
    stage_exerciser_if if256 ();

    stage_exerciser #(.NUM_VECTORS(16), .SEED(4'h1)) dut16 (
        .clk(clk), .rst(rst), .bus(if16.master));
    stage_exerciser #(.NUM_VECTORS(256), .SEED(4'h7)) dut256 (
        .clk(clk), .rst(rst), .bus(if256.master));

    function automatic logic [3:0] xf(input logic t, input logic [3:0] v);
        return t ? v + 4'h1 : v ^ 4'hC;
    endfunction

    // stage under test models: one register, transform on the output
    logic       type16, stuck16, type256;
    logic [3:0] st16, st256;
    logic [3:0] ctbl [16];
    always @(posedge clk) begin
        st16  <= rst ? 4'h0 : if16.stage_from;
        st256 <= rst ? 4'h0 : if256.stage_from;
    end
    assign if16.stage_to  = stuck16 ? 4'h0 : (xf(type16, st16) ^ ctbl[st16]);
    assign if256.stage_to = xf(type256, st256) ^ 4'h1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // whole-run outcome from the rules: vector i is (i mod 16) ^ seed, compared with its transform
    task automatic model(input logic m, input int n, input logic [3:0] seed,
                         output int err, output int fidx, output int fdata);
        logic [3:0] v, e, a;
        err = 0; fidx = 0; fdata = 0;
        for (int i = 0; i < n; i++) begin
            v = 4'(i % 16) ^ seed;
            e = m ? 4'((int'(v) + 1) % 16) : (v ^ 4'hC);
            a = stuck16 ? 4'h0 : (xf(type16, v) ^ ctbl[v]);
            if (a != e) begin
                if (err == 0) begin fidx = i; fdata = int'(a); end
                err++;
            end
        end
        if (err > 255) err = 255;
    endtask

    task automatic run16(input logic m, input bit mid, output int lat, output int busy_n,
                         output int seq_bad);
        logic [3:0] v;
        lat = 0; busy_n = 0; seq_bad = 0;
        if16.start = 1'b1;
        if16.mode  = m;
        step();
        if16.start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 1 && (if16.done || if16.err_count != 8'd0 || !if16.busy)) seq_bad++;
            if (if16.done) begin lat = k; break; end
            if (if16.busy) busy_n++;
            if (k <= 16) begin
                v = 4'(k - 1) ^ 4'h1;
                if (if16.stage_from !== v) seq_bad++;
            end
            if16.start = mid && (k == 6);
            if (mid && k == 6) if16.mode = ~m;
            step();
        end
        if16.start = 1'b0;
        if16.mode  = m;
    endtask

    typedef struct {
        logic m;
        logic t;
        logic stuck;
        int   err;
        int   fidx;
        int   fdata;
        int   pass;
    } vec_t;
    vec_t tbl [6];

    int lat, busy_n, seq_bad, e_err, e_fidx, e_fdata;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0,  0, 0, 0,  1};
        tbl[1] = '{1'b1, 1'b1, 1'b0,  0, 0, 0,  1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 15, 0, 0,  0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 16, 0, 2,  0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 16, 0, 13, 0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 15, 0, 0,  0};

        for (int i = 0; i < 16; i++) ctbl[i] = 4'h0;
        type16 = 1'b0; stuck16 = 1'b0; type256 = 1'b1;
        if16.start = 1'b0; if16.mode = 1'b0;
        if256.start = 1'b0; if256.mode = 1'b0;

        rst = 1'b1;
        if16.start = 1'b1;
        step(); step();
        chk("rst_from", int'(if16.stage_from), 0);
        chk("rst_busy", int'(if16.busy), 0);
        chk("rst_done", int'(if16.done), 0);
        chk("rst_pass", int'(if16.pass), 0);
        chk("rst_err", int'(if16.err_count), 0);
        chk("rst_fidx", int'(if16.first_err_idx), 0);
        chk("rst_fdata", int'(if16.first_err_data), 0);
        if16.start = 1'b0;
        rst = 1'b0;
        step();
        chk("idle_busy", int'(if16.busy), 0);

        for (int r = 0; r < 6; r++) begin
            type16 = tbl[r].t; stuck16 = tbl[r].stuck;
            run16(tbl[r].m, 1'b0, lat, busy_n, seq_bad);
            chk($sformatf("tbl%0d_lat", r), lat, 18);
            chk($sformatf("tbl%0d_busy", r), busy_n, 17);
            chk($sformatf("tbl%0d_seq", r), seq_bad, 0);
            chk($sformatf("tbl%0d_err", r), int'(if16.err_count), tbl[r].err);
            chk($sformatf("tbl%0d_fidx", r), int'(if16.first_err_idx), tbl[r].fidx);
            chk($sformatf("tbl%0d_fdata", r), int'(if16.first_err_data), tbl[r].fdata);
            chk($sformatf("tbl%0d_pass", r), int'(if16.pass), tbl[r].pass);
        end

        for (int r = 0; r < 8; r++) begin
            type16  = 1'($urandom_range(0, 1));
            stuck16 = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < 16; i++)
                ctbl[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            if16.mode = 1'($urandom_range(0, 1));
            model(if16.mode, 16, 4'h1, e_err, e_fidx, e_fdata);
            run16(if16.mode, 1'b0, lat, busy_n, seq_bad);
            chk($sformatf("rnd%0d_lat", r), lat, 18);
            chk($sformatf("rnd%0d_seq", r), seq_bad, 0);
            chk($sformatf("rnd%0d_err", r), int'(if16.err_count), e_err);
            chk($sformatf("rnd%0d_fidx", r), int'(if16.first_err_idx), e_fidx);
            chk($sformatf("rnd%0d_fdata", r), int'(if16.first_err_data), e_fdata);
            chk($sformatf("rnd%0d_pass", r), int'(if16.pass), (e_err == 0) ? 1 : 0);
        end
        for (int i = 0; i < 16; i++) ctbl[i] = 4'h0;

        // reset on the 5th RUN cycle with a failing stage: three errors already counted
        type16 = 1'b1; stuck16 = 1'b1;
        if16.mode = 1'b1; if16.start = 1'b1;
        step();
        if16.start = 1'b0;
        step(); step(); step(); step();
        chk("mid_busy_pre", int'(if16.busy), 1);
        chk("mid_err_pre", int'(if16.err_count), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_busy", int'(if16.busy), 0);
        chk("mid_from", int'(if16.stage_from), 0);
        chk("mid_err", int'(if16.err_count), 0);
        chk("mid_done", int'(if16.done), 0);
        step(); step();
        chk("mid_quiet_err", int'(if16.err_count), 0);
        stuck16 = 1'b0;
        run16(1'b1, 1'b0, lat, busy_n, seq_bad);
        chk("post_rst_lat", lat, 18);
        chk("post_rst_pass", int'(if16.pass), 1);

        // start and mode changes while busy are ignored
        type16 = 1'b0;
        run16(1'b0, 1'b1, lat, busy_n, seq_bad);
        chk("restart_lat", lat, 18);
        chk("restart_seq", seq_bad, 0);
        chk("restart_err", int'(if16.err_count), 0);
        chk("restart_pass", int'(if16.pass), 1);

        // results hold in DONE, then a new start clears them
        stuck16 = 1'b1;
        step(); step(); step();
        chk("hold_done", int'(if16.done), 1);
        chk("hold_pass", int'(if16.pass), 1);
        run16(1'b0, 1'b0, lat, busy_n, seq_bad);
        chk("rerun_lat", lat, 18);
        chk("rerun_seq", seq_bad, 0);
        chk("rerun_err", int'(if16.err_count), 15);
        chk("rerun_pass", int'(if16.pass), 0);

        // 256 vectors, every response off by one bit: count saturates
        lat = 0;
        if256.mode = 1'b1; if256.start = 1'b1;
        step();
        if256.start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (if256.done) begin lat = k; break; end
            step();
        end
        chk("n256_lat", lat, 258);
        chk("n256_err", int'(if256.err_count), 255);
        chk("n256_fidx", int'(if256.first_err_idx), 0);
        chk("n256_fdata", int'(if256.first_err_data), 9);
        chk("n256_pass", int'(if256.pass), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
